sargantana_icache_controller: RTL and testbench
===============================================

// Module: sargantana_icache_controller
// PURPOSE
//  Control FSM of the Sargantana L1 instruction cache. Accepts fetch requests, sequences tag compare,
//  TLB translation, IFILL miss handling and flush. Sits between the fetch stage, MMU/TLB,
//  tag/data arrays and the IFILL memory interface. Datapath only via enables and status flags.
// PARAMETERS
//  ICACHE_N_SET  4  ways per set; width of cline_hit_i (from shared package)
// PORTS
//  clk_i  in 1 clock; one clock domain | rst_i  in 1 reset, synchronous, active-high
//  cache_enable_i in 1 CSR cache enable | paddr_is_nc_i in 1 translated address non-cacheable
//  flush_i in 1 flush request | flush_done_i in 1 array invalidation finished
//  ireq_valid_i in 1 new fetch request | ireq_kill_s1_i in 1 kill request this cycle | ireq_kill_s2_i in 1 kill request in flight
//  mmu_resp_valid_i in 1 translation valid | mmu_ex_valid_i in 1 translation exception
//  ifill_resp_valid_i in 1 fill data valid | ifill_resp_ack_i in 1 fill complete | ifill_sent_ack_i in 1 fill request accepted
//  cline_hit_i in ICACHE_N_SET per-way tag match
//  iresp_ready_o out 1 can accept request | iresp_valid_o out 1 response valid | cmp_enable_o out 1 tag compare enable
//  cache_rd_ena_o out 1 array read | cache_wr_ena_o out 1 array write (refill) | treq_valid_o out 1 translation request
//  ifill_req_valid_o out 1 fill request | flush_en_o out 1 flush in progress | miss_o out 1 miss pulse
// BEHAVIOUR
//  States: IDLE, READ, TLB_WAIT, MISS, FILL_WAIT, KILL_MISS, FLUSH. 2-bit+ encoded, registered.
//  Reset (rst_i=1 at posedge): state<=IDLE, nc_q<=0; all outputs 0 while rst_i high.
//  hit = cache_enable_i & ~paddr_is_nc_i & |cline_hit_i.  Priority per state: rst > flush > kill > other.
//  IDLE: iresp_ready_o=1. flush_i -> FLUSH. ireq_valid_i & ~ireq_kill_s1_i: cache_rd_ena_o=1, treq_valid_o=1 -> READ.
//  READ: cmp_enable_o=1. ireq_kill_s2_i -> IDLE (no response). ~mmu_resp_valid_i -> TLB_WAIT.
//   mmu_ex_valid_i -> iresp_valid_o=1, IDLE. hit -> iresp_valid_o=1 (same cycle), IDLE.
//   else miss_o=1 (1-cycle), ifill_req_valid_o=1, nc_q<=~cache_enable_i|paddr_is_nc_i -> MISS.
//  TLB_WAIT: treq_valid_o=1 held. kill_s2 -> IDLE. mmu_resp_valid_i -> cache_rd_ena_o=1 -> READ (replay).
//  MISS: ifill_req_valid_o=1 held until ifill_sent_ack_i -> FILL_WAIT. kill_s2 -> KILL_MISS (request still completes).
//  FILL_WAIT: ifill_resp_valid_i -> cache_wr_ena_o=~nc_q, iresp_valid_o=1 same cycle; ifill_resp_ack_i -> IDLE.
//   kill_s2 -> KILL_MISS.  Simultaneous sent_ack & resp_valid in MISS: treat as FILL_WAIT response (direct to IDLE on ack).
//  KILL_MISS: iresp_valid_o=0, cache_wr_ena_o=~nc_q on fill data (keeps array coherent); ifill_resp_ack_i -> IDLE.
//  FLUSH: flush_en_o=1, iresp_ready_o=0; flush_done_i -> IDLE. flush_i ignored outside IDLE until return to IDLE.
//  Latency: hit with TLB hit = 1 cycle after acceptance; iresp_ready_o=0 in every state except IDLE (and READ, see below).
// CONFIGURATION
//  ICTRL_PIPELINE_EN defined: in READ, iresp_ready_o=1; on hit/exception with ireq_valid_i & ~ireq_kill_s1_i,
//   cache_rd_ena_o=1, treq_valid_o=1, stay READ -> one response per cycle for back-to-back hits.
//  Undefined: READ always returns to IDLE; next request accepted one cycle later (1 resp / 2 cycles).
// STRUCTURE
//  Package sargantana_icache_pkg: ICACHE_N_SET, state enum ictrl_state_t. Single module, no sub-modules;
//  one always_ff state/nc_q register, one always_comb next-state/output decode.
// TESTING
//  1 TLB miss + NC: ireq 1 cyc, mmu_resp after 6 cyc, sent_ack next, resp_valid+ack 6 cyc later ->
//    treq held 6 cyc, READ, miss_o 1 pulse, ifill_req until ack, iresp_valid=1 with cache_wr_ena=0, IDLE.
//  2 TLB hit, cacheable miss (cline_hit=0, enable=1): mmu_resp+sent_ack next cyc -> miss_o, FILL_WAIT,
//    on resp_valid cache_wr_ena=1 & iresp_valid=1 same cycle, IDLE.
//  3 Hit: ireq, next cyc mmu_resp=1, enable=1, cline_hit=4'b0001 -> iresp_valid=1 that cycle, cmp_enable=1, IDLE.
//  4 Back-to-back (PIPELINE_EN): ireq held 4 cyc, hits 0001/0010/1000 -> iresp_valid 1 on 4 consecutive
//    cycles, rd_ena every request cycle; without macro responses every other cycle.
//  5 Kill: kill_s2 in FILL_WAIT -> no iresp_valid; fill data written; IDLE after resp_ack.
//  6 Flush: flush_i in IDLE -> flush_en=1, iresp_ready=0 until flush_done; rst_i mid-MISS -> IDLE, outputs 0.

Source files
------------

// File: rtl/sargantana_icache_pkg.sv
// Shared types for the Sargantana L1 instruction cache control path.
// Holds the way count and the controller state encoding.
package sargantana_icache_pkg;

    localparam int ICACHE_N_SET = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_READ      = 3'd1,
        ST_TLB_WAIT  = 3'd2,
        ST_MISS      = 3'd3,
        ST_FILL_WAIT = 3'd4,
        ST_KILL_MISS = 3'd5,
        ST_FLUSH     = 3'd6
    } ictrl_state_t;

endpackage

// File: rtl/sargantana_icache_controller.sv
// Sargantana L1 icache control FSM: lookup, TLB wait, IFILL miss handling, flush.
// Optional macro ICTRL_PIPELINE_EN lets READ accept a new request on a hit (one response per cycle).
module sargantana_icache_controller
    import sargantana_icache_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cache_enable_i,
    input  logic                    paddr_is_nc_i,
    input  logic                    flush_i,
    input  logic                    flush_done_i,
    input  logic                    ireq_valid_i,
    input  logic                    ireq_kill_s1_i,
    input  logic                    ireq_kill_s2_i,
    input  logic                    mmu_resp_valid_i,
    input  logic                    mmu_ex_valid_i,
    input  logic                    ifill_resp_valid_i,
    input  logic                    ifill_resp_ack_i,
    input  logic                    ifill_sent_ack_i,
    input  logic [ICACHE_N_SET-1:0] cline_hit_i,
    output logic                    iresp_ready_o,
    output logic                    iresp_valid_o,
    output logic                    cmp_enable_o,
    output logic                    cache_rd_ena_o,
    output logic                    cache_wr_ena_o,
    output logic                    treq_valid_o,
    output logic                    ifill_req_valid_o,
    output logic                    flush_en_o,
    output logic                    miss_o
);

    ictrl_state_t state_q, state_d;
    logic         nc_q, nc_d;
    logic         hit;
    logic         new_req;

    assign hit     = cache_enable_i & ~paddr_is_nc_i & (|cline_hit_i);
    assign new_req = ireq_valid_i & ~ireq_kill_s1_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            nc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            nc_q    <= nc_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        nc_d              = nc_q;
        iresp_ready_o     = 1'b0;
        iresp_valid_o     = 1'b0;
        cmp_enable_o      = 1'b0;
        cache_rd_ena_o    = 1'b0;
        cache_wr_ena_o    = 1'b0;
        treq_valid_o      = 1'b0;
        ifill_req_valid_o = 1'b0;
        flush_en_o        = 1'b0;
        miss_o            = 1'b0;

        case (state_q)
            ST_IDLE: begin
                iresp_ready_o = 1'b1;
                if (flush_i) begin
                    state_d = ST_FLUSH;
                end else if (new_req) begin
                    cache_rd_ena_o = 1'b1;
                    treq_valid_o   = 1'b1;
                    state_d        = ST_READ;
                end
            end

            ST_READ: begin
                cmp_enable_o = 1'b1;
`ifdef ICTRL_PIPELINE_EN
                iresp_ready_o = 1'b1;
`endif
                if (ireq_kill_s2_i) begin
                    state_d = ST_IDLE;
                end else if (!mmu_resp_valid_i) begin
                    state_d = ST_TLB_WAIT;
                end else if (mmu_ex_valid_i || hit) begin
                    iresp_valid_o = 1'b1;
                    state_d       = ST_IDLE;
`ifdef ICTRL_PIPELINE_EN
                    // Overlap the next lookup with this response.
                    if (new_req) begin
                        cache_rd_ena_o = 1'b1;
                        treq_valid_o   = 1'b1;
                        state_d        = ST_READ;
                    end
`endif
                end else begin
                    miss_o            = 1'b1;
                    ifill_req_valid_o = 1'b1;
                    nc_d              = ~cache_enable_i | paddr_is_nc_i;
                    state_d           = ST_MISS;
                end
            end

            ST_TLB_WAIT: begin
                treq_valid_o = 1'b1;
                if (ireq_kill_s2_i) begin
                    state_d = ST_IDLE;
                end else if (mmu_resp_valid_i) begin
                    cache_rd_ena_o = 1'b1;
                    state_d        = ST_READ;
                end
            end

            ST_MISS: begin
                ifill_req_valid_o = 1'b1;
                if (ireq_kill_s2_i) begin
                    // Outstanding fill still completes; only the response is dropped.
                    if (ifill_sent_ack_i && ifill_resp_valid_i) begin
                        cache_wr_ena_o = ~nc_q;
                    end
                    state_d = (ifill_sent_ack_i && ifill_resp_ack_i) ? ST_IDLE : ST_KILL_MISS;
                end else if (ifill_sent_ack_i) begin
                    if (ifill_resp_valid_i) begin
                        cache_wr_ena_o = ~nc_q;
                        iresp_valid_o  = 1'b1;
                    end
                    state_d = ifill_resp_ack_i ? ST_IDLE : ST_FILL_WAIT;
                end
            end

            ST_FILL_WAIT: begin
                if (ireq_kill_s2_i) begin
                    cache_wr_ena_o = ifill_resp_valid_i & ~nc_q;
                    state_d        = ifill_resp_ack_i ? ST_IDLE : ST_KILL_MISS;
                end else begin
                    if (ifill_resp_valid_i) begin
                        cache_wr_ena_o = ~nc_q;
                        iresp_valid_o  = 1'b1;
                    end
                    if (ifill_resp_ack_i) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_KILL_MISS: begin
                cache_wr_ena_o = ifill_resp_valid_i & ~nc_q;
                if (ifill_resp_ack_i) begin
                    state_d = ST_IDLE;
                end
            end

            ST_FLUSH: begin
                flush_en_o = 1'b1;
                if (flush_done_i) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Nothing leaves the controller while reset is held.
        if (rst_i) begin
            iresp_ready_o     = 1'b0;
            iresp_valid_o     = 1'b0;
            cmp_enable_o      = 1'b0;
            cache_rd_ena_o    = 1'b0;
            cache_wr_ena_o    = 1'b0;
            treq_valid_o      = 1'b0;
            ifill_req_valid_o = 1'b0;
            flush_en_o        = 1'b0;
            miss_o            = 1'b0;
        end
    end

endmodule

// File: tb/tb_sargantana_icache_controller.sv
// Self-checking bench for sargantana_icache_controller: directed scenarios plus
// randomized transactions whose per-cycle outputs are scripted from transaction parameters.
module tb_sargantana_icache_controller;

    localparam int NW = sargantana_icache_pkg::ICACHE_N_SET;
`ifdef ICTRL_PIPELINE_EN
    localparam bit PIPE = 1'b1;
`else
    localparam bit PIPE = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, cache_enable, paddr_is_nc, flush, flush_done;
    logic          ireq_valid, ireq_kill_s1, ireq_kill_s2;
    logic          mmu_resp_valid, mmu_ex_valid;
    logic          ifill_resp_valid, ifill_resp_ack, ifill_sent_ack;
    logic [NW-1:0] cline_hit;
    logic          iresp_ready, iresp_valid, cmp_enable, cache_rd_ena, cache_wr_ena;
    logic          treq_valid, ifill_req_valid, flush_en, miss;

    sargantana_icache_controller dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .cache_enable_i     (cache_enable),
        .paddr_is_nc_i      (paddr_is_nc),
        .flush_i            (flush),
        .flush_done_i       (flush_done),
        .ireq_valid_i       (ireq_valid),
        .ireq_kill_s1_i     (ireq_kill_s1),
        .ireq_kill_s2_i     (ireq_kill_s2),
        .mmu_resp_valid_i   (mmu_resp_valid),
        .mmu_ex_valid_i     (mmu_ex_valid),
        .ifill_resp_valid_i (ifill_resp_valid),
        .ifill_resp_ack_i   (ifill_resp_ack),
        .ifill_sent_ack_i   (ifill_sent_ack),
        .cline_hit_i        (cline_hit),
        .iresp_ready_o      (iresp_ready),
        .iresp_valid_o      (iresp_valid),
        .cmp_enable_o       (cmp_enable),
        .cache_rd_ena_o     (cache_rd_ena),
        .cache_wr_ena_o     (cache_wr_ena),
        .treq_valid_o       (treq_valid),
        .ifill_req_valid_o  (ifill_req_valid),
        .flush_en_o         (flush_en),
        .miss_o             (miss)
    );

    // Output bundle order: ready, valid, cmp, rd, wr, treq, ifill, flush_en, miss
    logic [8:0] obs;
    assign obs = {iresp_ready, iresp_valid, cmp_enable, cache_rd_ena, cache_wr_ena,
                  treq_valid, ifill_req_valid, flush_en, miss};

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (rdy vld cmp rd wr treq ifill fl miss)", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] ev(input bit rdy, input bit vld, input bit cmp, input bit rd,
                                      input bit wr, input bit tq, input bit fq, input bit fl,
                                      input bit ms);
        return {rdy, vld, cmp, rd, wr, tq, fq, fl, ms};
    endfunction

    task automatic clr_pulses();
        flush = 0; flush_done = 0; ireq_valid = 0; ireq_kill_s1 = 0; ireq_kill_s2 = 0;
        mmu_resp_valid = 0; mmu_ex_valid = 0;
        ifill_resp_valid = 0; ifill_resp_ack = 0; ifill_sent_ack = 0;
    endtask

    // Check one cycle's outputs for the inputs already applied, then advance.
    task automatic cyc(input string tag, input logic [8:0] exp);
        @(negedge clk);
        check(tag, obs, exp);
        @(posedge clk);
        #1;
        clr_pulses();
    endtask

    task automatic idle_chk(input string tag);
        cyc(tag, ev(1,0,0,0,0,0,0,0,0));
    endtask

    // One fetch transaction described by its timing parameters.
    // kill: 0 none, 1 kill_s2 in the first FILL_WAIT cycle, 2 kill_s2 in the first READ cycle.
    task automatic fetch(input int tlb_dly, input bit ex, input bit en, input bit nc,
                         input logic [NW-1:0] mask, input int sent_dly, input int resp_dly,
                         input int kill);
        bit hit, ncq;
        hit = en && !nc && (mask != 0);
        ncq = !en || nc;
        cache_enable = en; paddr_is_nc = nc; cline_hit = mask;
        ireq_valid = 1;
        cyc("accept", ev(1,0,0,1,0,1,0,0,0));
        if (kill == 2) begin
            ireq_kill_s2 = 1;
            cyc("kill_read", ev(PIPE,0,1,0,0,0,0,0,0));
            idle_chk("idle_after_kill_read");
            return;
        end
        if (tlb_dly > 0) begin
            cyc("read_tlb_miss", ev(PIPE,0,1,0,0,0,0,0,0));
            for (int i = 1; i < tlb_dly; i++) cyc("tlb_wait", ev(0,0,0,0,0,1,0,0,0));
            mmu_resp_valid = 1;
            cyc("tlb_done", ev(0,0,0,1,0,1,0,0,0));
        end
        mmu_resp_valid = 1; mmu_ex_valid = ex;
        if (ex || hit) begin
            cyc("read_resp", ev(PIPE,1,1,0,0,0,0,0,0));
        end else begin
            cyc("read_miss", ev(PIPE,0,1,0,0,0,1,0,1));
            for (int i = 0; i < sent_dly; i++) cyc("miss_wait", ev(0,0,0,0,0,0,1,0,0));
            ifill_sent_ack = 1;
            if (resp_dly == 0) begin
                ifill_resp_valid = 1; ifill_resp_ack = 1;
                cyc("miss_direct_fill", ev(0,1,0,0,!ncq,0,1,0,0));
            end else begin
                cyc("miss_sent", ev(0,0,0,0,0,0,1,0,0));
                if (kill == 1) begin
                    ireq_kill_s2 = 1;
                    cyc("kill_fill_wait", ev(0,0,0,0,0,0,0,0,0));
                    for (int i = 1; i < resp_dly; i++) cyc("kill_wait", ev(0,0,0,0,0,0,0,0,0));
                    ifill_resp_valid = 1; ifill_resp_ack = 1;
                    cyc("kill_fill", ev(0,0,0,0,!ncq,0,0,0,0));
                end else begin
                    for (int i = 1; i < resp_dly; i++) cyc("fill_wait", ev(0,0,0,0,0,0,0,0,0));
                    ifill_resp_valid = 1; ifill_resp_ack = 1;
                    cyc("fill", ev(0,1,0,0,!ncq,0,0,0,0));
                end
            end
        end
        idle_chk("idle_after_fetch");
    endtask

    // n requests back to back, all TLB hits and cache hits.
    task automatic b2b(input int n);
        logic [NW-1:0] m;
        cache_enable = 1; paddr_is_nc = 0;
        if (PIPE) begin
            ireq_valid = 1;
            cyc("b2b_accept", ev(1,0,0,1,0,1,0,0,0));
            for (int i = 0; i < n; i++) begin
                m = NW'($urandom_range(1, (1 << NW) - 1));
                cline_hit = m; mmu_resp_valid = 1; ireq_valid = (i < n - 1);
                cyc("b2b_pipe_resp", ev(1,1,1,i < n - 1,0,i < n - 1,0,0,0));
            end
        end else begin
            for (int i = 0; i < n; i++) begin
                ireq_valid = 1;
                cyc("b2b_accept", ev(1,0,0,1,0,1,0,0,0));
                m = NW'($urandom_range(1, (1 << NW) - 1));
                cline_hit = m; mmu_resp_valid = 1; ireq_valid = 1;
                cyc("b2b_resp", ev(0,1,1,0,0,0,0,0,0));
            end
        end
        idle_chk("idle_after_b2b");
    endtask

    task automatic do_flush(input int k);
        flush = 1; ireq_valid = 1'($urandom);
        cyc("flush_req", ev(1,0,0,0,0,0,0,0,0));
        for (int i = 0; i < k; i++) begin
            flush = 1'($urandom); ireq_valid = 1'($urandom);
            cyc("flushing", ev(0,0,0,0,0,0,0,1,0));
        end
        flush_done = 1;
        cyc("flush_done", ev(0,0,0,0,0,0,0,1,0));
        idle_chk("idle_after_flush");
    endtask

    task automatic reset_mid_miss();
        cache_enable = 1; paddr_is_nc = 0; cline_hit = '0;
        ireq_valid = 1;
        cyc("rm_accept", ev(1,0,0,1,0,1,0,0,0));
        mmu_resp_valid = 1;
        cyc("rm_read_miss", ev(PIPE,0,1,0,0,0,1,0,1));
        cyc("rm_miss", ev(0,0,0,0,0,0,1,0,0));
        rst = 1; ifill_sent_ack = 1; ifill_resp_valid = 1; ireq_valid = 1;
        cyc("rm_reset_outputs", ev(0,0,0,0,0,0,0,0,0));
        rst = 0;
        idle_chk("rm_idle");
    endtask

    initial begin
        rst = 1; cache_enable = 0; paddr_is_nc = 0; cline_hit = '0;
        clr_pulses();
        #1;
        cyc("reset0", ev(0,0,0,0,0,0,0,0,0));
        ireq_valid = 1; flush = 1;
        cyc("reset1", ev(0,0,0,0,0,0,0,0,0));
        rst = 0;
        idle_chk("idle_after_reset");

        // Kill in the request cycle is never accepted.
        ireq_valid = 1; ireq_kill_s1 = 1;
        cyc("kill_s1", ev(1,0,0,0,0,0,0,0,0));
        idle_chk("idle_after_kill_s1");

        fetch(6, 0, 1, 1, 4'b0001, 0, 6, 0);   // TLB miss, non-cacheable
        fetch(0, 0, 1, 0, 4'b0000, 0, 1, 0);   // cacheable miss
        fetch(0, 0, 1, 0, 4'b0001, 0, 0, 0);   // hit
        fetch(0, 1, 1, 0, 4'b0000, 0, 0, 0);   // translation exception
        fetch(0, 0, 0, 0, 4'b0100, 1, 0, 0);   // cache disabled: miss, no write, direct fill
        b2b(4);
        fetch(0, 0, 1, 0, 4'b0000, 1, 3, 1);   // kill during fill
        fetch(2, 0, 1, 0, 4'b0010, 0, 0, 2);   // kill in READ
        do_flush(3);
        reset_mid_miss();

        for (int t = 0; t < 40; t++) begin
            int kind, k, kill, rd;
            kind = $urandom_range(0, 5);
            if (kind == 0) begin
                b2b($urandom_range(1, 5));
            end else if (kind == 1) begin
                do_flush($urandom_range(0, 4));
            end else begin
                rd = $urandom_range(0, 3);
                k = $urandom_range(0, 3);
                kill = (k == 1) ? 1 : (k == 2) ? 2 : 0;
                if (kill == 1 && rd == 0) kill = 0;
                fetch($urandom_range(0, 3), $urandom_range(0, 5) == 0, 1'($urandom),
                      1'($urandom), NW'($urandom), $urandom_range(0, 2), rd, kill);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
